// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer: FSM state encoding, register
// offsets, reset/default values and the address-error rule.
package apb_pkg;

    // Transfer state: IDLE waits for a setup phase, ACCESS counts wait
    // states and then completes the transfer.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // Byte offsets of the register map.
    localparam logic [7:0] OFF_REG0    = 8'h00;
    localparam logic [7:0] OFF_REG1    = 8'h04;
    localparam logic [7:0] OFF_REG2    = 8'h08;
    localparam logic [7:0] OFF_VERSION = 8'h0C;

    // Default contents of the read-only identification register.
    localparam logic [31:0] VERSION_DEFAULT = 32'h0000_0100;

    // Number of writable registers and width of the wait-state counter.
    localparam int NUM_RW_REGS = 3;
    localparam int CNT_W       = 4;

    // An access errors when it is misaligned, falls past the last register,
    // or tries to write the read-only identification register.
    function automatic logic addr_error(input logic [7:0] addr, input logic write);
        return (addr[1:0] != 2'b00) || (addr > OFF_VERSION) ||
               (write && (addr == OFF_VERSION));
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: three byte-strobed RW registers
// plus a read-only identification word, with a zero-latency read mux.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [1:0]  widx_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic [1:0]  ridx_i,
    output logic [31:0] rdata_o
);

    // Flattened view of the register contents for the read mux.
    logic [NUM_RW_REGS-1:0][31:0] regs_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RW_REGS; gi++) begin : g_reg
            localparam logic [1:0] IDX = 2'(gi);
            logic [31:0] reg_q;
            logic        sel_w;

            assign sel_w      = we_i && (widx_i == IDX);
            assign regs_w[gi] = reg_q;

            // Merge the write data into this register lane by lane.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else if (sel_w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_i[b]) begin
                            reg_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    // Select the addressed word; index 3 is the identification register.
    always_comb begin
        rdata_o = '0;
        case (ridx_i)
            2'd0:    rdata_o = regs_w[0];
            2'd1:    rdata_o = regs_w[1];
            2'd2:    rdata_o = regs_w[2];
            default: rdata_o = VERSION;
        endcase
    end

endmodule

// File: rtl/apb_completer.sv
// APB completer: two-state transfer FSM with a programmable number of
// access-phase wait states, address error decode and a small register bank.
module apb_completer
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,           // 0..15 wait states
    parameter logic [31:0] VERSION     = VERSION_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    apb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pwrite_q;
    logic             err_q;
    logic [1:0]       idx_q;

    logic             we_w;
    logic [31:0]      rdata_w;

    // Transfer FSM: capture the request at setup, count wait states, then
    // complete for exactly one cycle. Dropping psel abandons the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // penable high without a preceding setup is not a transfer
                    if (psel && !penable) begin
                        state_q  <= ST_ACCESS;
                        cnt_q    <= WAIT_LOAD;
                        pwrite_q <= pwrite;
                        err_q    <= addr_error(paddr, pwrite);
                        idx_q    <= paddr[3:2];
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Completion comes from registered state only, so bus inputs never
    // reach pready combinationally.
    assign pready = (state_q == ST_ACCESS) && (cnt_q == '0);

    // Commit only a live, error-free write in its completion cycle.
    assign we_w = pready && pwrite_q && !err_q && psel && penable;

    // Response data and error are forced to zero outside the completion cycle.
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !pwrite_q && !err_q) ? rdata_w : 32'h0;

    apb_reg_bank #(
        .VERSION (VERSION)
    ) u_reg_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_w),
        .widx_i  (idx_q),
        .wdata_i (pwdata),
        .wstrb_i (pstrb),
        .ridx_i  (idx_q),
        .rdata_o (rdata_w)
    );

endmodule

// File: tb/tb_apb_completer.sv
// Self-checking bench for apb_completer: three instances with 0, 2 and 3
// wait states, a directed vector table, hand-written abort/reset sequences
// and randomized traffic checked against a register-map model.
module tb_apb_completer;

    localparam int ND = 3;

    logic        clk;
    logic        rst_n;
    logic        psel    [ND];
    logic        penable [ND];
    logic        pwrite  [ND];
    logic [7:0]  paddr   [ND];
    logic [31:0] pwdata  [ND];
    logic [3:0]  pstrb   [ND];
    logic [31:0] prdata  [ND];
    logic        pready  [ND];
    logic        pslverr [ND];

    int checks;
    int failures;

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            localparam int unsigned W = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
            apb_completer #(.WAIT_CYCLES(W)) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .psel    (psel[gi]),
                .penable (penable[gi]),
                .pwrite  (pwrite[gi]),
                .paddr   (paddr[gi]),
                .pwdata  (pwdata[gi]),
                .pstrb   (pstrb[gi]),
                .prdata  (prdata[gi]),
                .pready  (pready[gi]),
                .pslverr (pslverr[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mregs [ND][3];

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic m_err(input logic wr, input logic [7:0] a);
        return (a % 4 != 0) || (a > 8'd12) || (wr && a == 8'd12);
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [7:0] a);
        if (a == 8'd12) return 32'h0000_0100;
        return mregs[d][int'(a) / 4];
    endfunction

    task automatic m_write(input int d, input logic [7:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
        for (int b = 0; b < 4; b++)
            if (st[b]) mregs[d][int'(a) / 4][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic m_clear();
        for (int d = 0; d < ND; d++)
            for (int r = 0; r < 3; r++)
                mregs[d][r] = 32'h0;
    endtask

    // ---------------- comparison helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- bus helpers ----------------
    task automatic bus_idle();
        for (int d = 0; d < ND; d++) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // One APB transfer on instance d; lat = cycles from setup to pready
    // (0 on timeout). quiet is cleared if pready/pslverr/prdata misbehave
    // before completion.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err,
                        output int lat, output bit quiet);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        quiet = 1'b1; lat = 0; rd = 32'h0; err = 1'b0;
        if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) quiet = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            penable[d] = 1'b1;
            if (pready[d] === 1'b1) begin
                rd  = prdata[d];
                err = pslverr[d];
                lat = c;
                break;
            end
            if (pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) quiet = 1'b0;
        end
    endtask

    task automatic run_and_check(input string tag, input int d, input logic wr,
                                 input logic [7:0] a, input logic [31:0] wd,
                                 input logic [3:0] st, input logic [31:0] exp_rd,
                                 input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          quiet;
        xfer(d, wr, a, wd, st, rd, err, lat, quiet);
        $display("txn %s dut%0d %s addr=%02h wdata=%08h strb=%h -> prdata=%08h pslverr=%0d lat=%0d",
                 tag, d, wr ? "W" : "R", a, wd, st, rd, err, lat);
        check32($sformatf("%s_prdata", tag), rd, exp_rd);
        check32($sformatf("%s_pslverr", tag), {31'h0, err}, {31'h0, exp_err});
        check_int($sformatf("%s_latency", tag), lat, 1 + wait_of(d));
        check_int($sformatf("%s_quiet_wait", tag), int'(quiet), 1);
    endtask

    // Model-driven transfer: expectation from the model, then model update.
    task automatic model_xfer(input string tag, input int d, input logic wr,
                              input logic [7:0] a, input logic [31:0] wd,
                              input logic [3:0] st);
        logic        e;
        logic [31:0] r;
        e = m_err(wr, a);
        r = (wr || e) ? 32'h0 : m_read(d, a);
        run_and_check(tag, d, wr, a, wd, st, r, e);
        if (wr && !e) m_write(d, a, wd, st);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          d;
        logic        wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin : main
        logic [7:0]  ra;
        logic [31:0] rv;
        bit          seen;
        int          rd_lat;
        logic [31:0] dummy_rd;
        logic        dummy_err;
        bit          dummy_quiet;
        logic [7:0]  addr_pool [5];

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0;
        end
        m_clear();

        //            d  wr   addr   wdata          strb   exp_rd         err
        vecs.push_back('{0, 1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0});
        vecs.push_back('{0, 1'b0, 8'h00, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{2, 1'b0, 8'h0C, 32'h00000000, 4'h0, 32'h00000100, 1'b0});
        vecs.push_back('{0, 1'b1, 8'h04, 32'h11223344, 4'hF, 32'h00000000, 1'b0});
        vecs.push_back('{0, 1'b1, 8'h04, 32'hAABBCCDD, 4'h5, 32'h00000000, 1'b0});
        vecs.push_back('{0, 1'b0, 8'h04, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{0, 1'b1, 8'h0C, 32'h12345678, 4'hF, 32'h00000000, 1'b1});
        vecs.push_back('{0, 1'b0, 8'h10, 32'h00000000, 4'h0, 32'h00000000, 1'b1});
        vecs.push_back('{0, 1'b0, 8'h02, 32'h00000000, 4'h0, 32'h00000000, 1'b1});
        vecs.push_back('{0, 1'b0, 8'h0C, 32'h00000000, 4'h0, 32'h00000100, 1'b0});
        vecs.push_back('{0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1});
        vecs.push_back('{0, 1'b0, 8'h04, 32'h00000000, 4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0});
        vecs.push_back('{1, 1'b0, 8'h08, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{2, 1'b1, 8'h00, 32'h1234FFFF, 4'h3, 32'h00000000, 1'b0});
        vecs.push_back('{2, 1'b0, 8'h00, 32'h00000000, 4'h0, 32'h0000FFFF, 1'b0});

        // Outputs held at zero during reset.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check32($sformatf("reset_pready_dut%0d", d), {31'h0, pready[d]}, 32'h0);
            check32($sformatf("reset_pslverr_dut%0d", d), {31'h0, pslverr[d]}, 32'h0);
            check32($sformatf("reset_prdata_dut%0d", d), prdata[d], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, applied back to back.
        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].wr, vecs[i].a,
                          vecs[i].wd, vecs[i].st, vecs[i].exp_rd, vecs[i].exp_err);
            if (vecs[i].wr && !m_err(vecs[i].wr, vecs[i].a))
                m_write(vecs[i].d, vecs[i].a, vecs[i].wd, vecs[i].st);
        end

        // penable high in IDLE without a setup phase must not start a transfer.
        bus_idle();
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 8'h00;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (pready[0] !== 1'b0) seen = 1'b1;
        end
        check_int("no_setup_pready", int'(seen), 0);
        bus_idle();
        model_xfer("after_no_setup", 0, 1'b0, 8'h00, 32'h0, 4'h0);

        // Abort: write REG2 on the 2-wait instance, drop psel mid-wait.
        bus_idle();
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h08; pwdata[1] = 32'h0BAD0BAD; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        seen = (pready[1] !== 1'b0);
        @(posedge clk); #1;
        if (pready[1] !== 1'b0) seen = 1'b1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (pready[1] !== 1'b0) seen = 1'b1;
        end
        check_int("abort_no_pready", int'(seen), 0);
        model_xfer("abort_readback", 1, 1'b0, 8'h08, 32'h0, 4'h0);
        model_xfer("abort_next_write", 1, 1'b1, 8'h08, 32'h00C0FFEE, 4'hF);
        model_xfer("abort_next_read", 1, 1'b0, 8'h08, 32'h0, 4'h0);

        // Randomized traffic against the model.
        addr_pool[0] = 8'h00; addr_pool[1] = 8'h04; addr_pool[2] = 8'h08; addr_pool[3] = 8'h0C;
        for (int n = 0; n < 60; n++) begin
            int dd;
            dd = int'($urandom_range(0, ND - 1));
            addr_pool[4] = 8'($urandom_range(0, 255));
            ra = addr_pool[$urandom_range(0, 4)];
            rv = $urandom;
            model_xfer($sformatf("rnd%0d", n), dd, 1'($urandom_range(0, 1)), ra, rv,
                       4'($urandom_range(0, 15)));
        end

        // Make every register non-zero so the reset clearing is observable.
        bus_idle();
        for (int d = 0; d < ND; d++)
            for (int r = 0; r < 3; r++)
                model_xfer($sformatf("fill_d%0d_r%0d", d, r), d, 1'b1, 8'(4 * r),
                           32'hA5A50000 | 32'(16 * d + r + 1), 4'hF);

        // Reset asserted during the completion cycle of a write.
        bus_idle();
        xfer(2, 1'b1, 8'h00, 32'h12345678, 4'hF, dummy_rd, dummy_err, rd_lat, dummy_quiet);
        check_int("rst_mid_pready_seen", int'(pready[2] === 1'b1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check32($sformatf("rst_mid_pready_dut%0d", d), {31'h0, pready[d]}, 32'h0);
            check32($sformatf("rst_mid_pslverr_dut%0d", d), {31'h0, pslverr[d]}, 32'h0);
            check32($sformatf("rst_mid_prdata_dut%0d", d), prdata[d], 32'h0);
        end
        for (int d = 0; d < ND; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        for (int d = 0; d < ND; d++)
            for (int r = 0; r < 3; r++)
                run_and_check($sformatf("post_rst_d%0d_r%0d", d, r), d, 1'b0, 8'(4 * r),
                              32'h0, 4'h0, 32'h0, 1'b0);
        model_xfer("post_rst_write", 2, 1'b1, 8'h04, 32'h5A5A5A5A, 4'hF);
        model_xfer("post_rst_read", 2, 1'b0, 8'h04, 32'h0, 4'h0);

        bus_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound in case a transfer never completes.
    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
